// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32 load/store unit memory controller.
// Decodes load/store size and alignment, runs a req/gnt/rvalid data bus
// handshake and stalls the pipeline while an access is outstanding.
// Optional bus-wait timeout is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush_i,
  input  logic        mem_valid_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic [1:0]  byte_lane_o,
  output logic [1:0]  access_size_o,
  output logic        unsigned_load_o,
  output logic        align_err_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        bus_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_d;

  logic        misalign_c;
  logic        illegal_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic        accept_c;
  logic        busy_c;
  logic        timeout_c;

  // Size/alignment decode and byte-enable / replicated store data generation
  always_comb begin
    byte_lane_o     = addr_i[1:0];
    access_size_o   = funct3_i[1:0];
    unsigned_load_o = funct3_i[2];
    misalign_c      = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    illegal_c       = is_load_i ? ((funct3_i == 3'b011) || (funct3_i == 3'b110) ||
                                   (funct3_i == 3'b111))
                                : funct3_i[2];
    align_err_o     = (is_load_i || is_store_i) && (misalign_c || illegal_c);
    case (funct3_i[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr_i[1:0];
        wdata_c = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << addr_i[1:0];
        wdata_c = {2{wdata_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata_i;
      end
    endcase
  end

  assign accept_c = (state_q == S_IDLE) && mem_valid_i && (is_load_i || is_store_i) &&
                    !align_err_o && !flush_i;
  assign busy_c   = (state_q == S_REQ) || (state_q == S_RESP) || (state_q == S_DRAIN);

  // Next-state logic; completion and flush take priority over the timeout
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_REQ;
          addr_d  = {addr_i[31:2], 2'b00};
          be_d    = be_c;
          wdata_d = wdata_c;
          we_d    = is_store_i;
        end
      end
      S_REQ: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (dmem_gnt_i) begin
          state_d = S_RESP;
        end else if (timeout_c) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
        end
      end
      S_RESP: begin
        if (flush_i) begin
          // Granted request cannot be cancelled: drain its response
          state_d = dmem_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (dmem_rvalid_i) begin
          if (!we_q) begin
            rdata_d = dmem_rdata_i;
          end
          state_d = S_DONE;
        end else if (timeout_c) begin
          state_d   = S_DONE;
          bus_err_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (dmem_rvalid_i) begin
          state_d = S_IDLE;
        end else if (timeout_c) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and bus payload registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign stall_o      = busy_c || accept_c;
  assign done_o       = (state_q == S_DONE);
  assign dmem_req_o   = (state_q == S_REQ);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q;

  // Bus-wait counter: cleared on accept, counts every outstanding cycle
  always_comb begin
    cnt_d = cnt_q;
    if (accept_c) begin
      cnt_d = '0;
    end else if (busy_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter and one-cycle bus error pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign bus_err_o      = 1'b0;
  assign unused_timeout = ^{32'(TIMEOUT_CYCLES), bus_err_d};
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl. Inputs are driven on the falling
// edge and outputs sampled 1ns later. Timeout scenario needs LSU_TIMEOUT_EN.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rstn;
  logic        flush_i, mem_valid_i, is_load_i, is_store_i;
  logic [31:0] addr_i, wdata_i;
  logic [2:0]  funct3_i;
  logic [1:0]  byte_lane_o, access_size_o;
  logic        unsigned_load_o, align_err_o, stall_o, done_o, bus_err_o;
  logic [31:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int checks   = 0;
  int failures = 0;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .flush_i         (flush_i),
    .mem_valid_i     (mem_valid_i),
    .is_load_i       (is_load_i),
    .is_store_i      (is_store_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .funct3_i        (funct3_i),
    .byte_lane_o     (byte_lane_o),
    .access_size_o   (access_size_o),
    .unsigned_load_o (unsigned_load_o),
    .align_err_o     (align_err_o),
    .stall_o         (stall_o),
    .done_o          (done_o),
    .rdata_o         (rdata_o),
    .bus_err_o       (bus_err_o),
    .dmem_req_o      (dmem_req_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_be_o       (dmem_be_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_gnt_i      (dmem_gnt_i),
    .dmem_rvalid_i   (dmem_rvalid_i),
    .dmem_rdata_i    (dmem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_inputs();
    flush_i = 0; mem_valid_i = 0; is_load_i = 0; is_store_i = 0;
    addr_i = 0; wdata_i = 0; funct3_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
  endtask

  task automatic test_reset();
    logic [104:0] rv;
    rstn = 1'b0;
    clr_inputs();
    @(negedge clk); #1;
    rv = {stall_o, done_o, bus_err_o, dmem_req_o, dmem_we_o, dmem_addr_o,
          dmem_be_o, dmem_wdata_o, rdata_o};
    checks++;
    if (rv !== '0) begin
      $display("FAIL reset_outputs got=%h exp=0", rv); failures++;
    end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({stall_o, dmem_req_o, done_o} !== 3'b000) begin
      $display("FAIL post_reset_idle got=%b exp=000", {stall_o, dmem_req_o, done_o}); failures++;
    end
  endtask

  task automatic test_load_word();
    int stall_cnt = 0;
    int done_cnt  = 0;
    @(negedge clk);
    mem_valid_i = 1; is_load_i = 1; addr_i = 32'h100; funct3_i = 3'b010; #1;
    stall_cnt += int'(stall_o); done_cnt += int'(done_o);
    checks++;
    if ({align_err_o, access_size_o, stall_o, dmem_req_o} !== 5'b01010) begin
      $display("FAIL lw_accept got=%b exp=01010", {align_err_o, access_size_o, stall_o, dmem_req_o}); failures++;
    end
    @(negedge clk); dmem_gnt_i = 1; #1;
    stall_cnt += int'(stall_o); done_cnt += int'(done_o);
    checks++;
    if ({dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      $display("FAIL lw_req got=%b/%b/%h/%h exp=1/0/f/00000100", dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o); failures++;
    end
    @(negedge clk); dmem_gnt_i = 0; #1;
    stall_cnt += int'(stall_o); done_cnt += int'(done_o);
    checks++;
    if (dmem_req_o !== 1'b0) begin
      $display("FAIL lw_req_drop got=%b exp=0", dmem_req_o); failures++;
    end
    @(negedge clk); dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEADBEEF; #1;
    stall_cnt += int'(stall_o); done_cnt += int'(done_o);
    @(negedge clk); clr_inputs(); #1;
    stall_cnt += int'(stall_o); done_cnt += int'(done_o);
    checks++;
    if ({done_o, stall_o} !== 2'b10 || rdata_o !== 32'hDEADBEEF) begin
      $display("FAIL lw_done got=%b%b rdata=%h exp=10 rdata=deadbeef", done_o, stall_o, rdata_o); failures++;
    end
    @(negedge clk); #1;
    stall_cnt += int'(stall_o); done_cnt += int'(done_o);
    checks++;
    if (stall_cnt !== 4) begin
      $display("FAIL lw_stall_cycles got=%0d exp=4", stall_cnt); failures++;
    end
    checks++;
    if (done_cnt !== 1) begin
      $display("FAIL lw_done_cycles got=%0d exp=1", done_cnt); failures++;
    end
  endtask

  task automatic test_store_byte();
    @(negedge clk);
    mem_valid_i = 1; is_store_i = 1; addr_i = 32'h203; wdata_i = 32'h000000A5; funct3_i = 3'b000; #1;
    checks++;
    if ({byte_lane_o, access_size_o, align_err_o, stall_o} !== 6'b110001) begin
      $display("FAIL sb_decode got=%b exp=110001", {byte_lane_o, access_size_o, align_err_o, stall_o}); failures++;
    end
    @(negedge clk); dmem_gnt_i = 1; #1;
    checks++;
    if ({dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !==
        {1'b1, 1'b1, 4'b1000, 32'h200, 32'hA5A5A5A5}) begin
      $display("FAIL sb_bus got=%b/%b/%b/%h/%h exp=1/1/1000/00000200/a5a5a5a5",
               dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o); failures++;
    end
    @(negedge clk); dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'hFFFFFFFF; #1;
    @(negedge clk); clr_inputs(); #1;
    checks++;
    if (done_o !== 1'b1 || rdata_o !== 32'hDEADBEEF) begin
      $display("FAIL sb_done got=%b rdata=%h exp=1 rdata=deadbeef", done_o, rdata_o); failures++;
    end
  endtask

  task automatic test_store_half();
    @(negedge clk);
    mem_valid_i = 1; is_store_i = 1; addr_i = 32'h102; wdata_i = 32'h1234ABCD; funct3_i = 3'b001; #1;
    checks++;
    if (align_err_o !== 1'b0) begin
      $display("FAIL sh_align got=%b exp=0", align_err_o); failures++;
    end
    @(negedge clk); dmem_gnt_i = 1; #1;
    checks++;
    if ({dmem_be_o, dmem_addr_o, dmem_wdata_o} !== {4'b1100, 32'h100, 32'hABCDABCD}) begin
      $display("FAIL sh_bus got=%b/%h/%h exp=1100/00000100/abcdabcd", dmem_be_o, dmem_addr_o, dmem_wdata_o); failures++;
    end
    @(negedge clk); dmem_gnt_i = 0; dmem_rvalid_i = 1; #1;
    @(negedge clk); clr_inputs(); #1;
    checks++;
    if (done_o !== 1'b1) begin
      $display("FAIL sh_done got=%b exp=1", done_o); failures++;
    end
    @(negedge clk); #1;
  endtask

  task automatic test_align_err();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_valid_i = 1; is_load_i = 1; addr_i = 32'h101; funct3_i = 3'b001; #1;
      checks++;
      if ({align_err_o, stall_o, dmem_req_o} !== 3'b100) begin
        $display("FAIL lh_misalign cyc=%0d got=%b exp=100", i, {align_err_o, stall_o, dmem_req_o}); failures++;
      end
    end
    @(negedge clk); funct3_i = 3'b011; addr_i = 32'h0; #1;
    checks++;
    if ({align_err_o, dmem_req_o} !== 2'b10) begin
      $display("FAIL ld_illegal_f3 got=%b exp=10", {align_err_o, dmem_req_o}); failures++;
    end
    @(negedge clk); is_load_i = 0; is_store_i = 1; funct3_i = 3'b100; #1;
    checks++;
    if ({align_err_o, stall_o, dmem_req_o} !== 3'b100) begin
      $display("FAIL st_illegal_f3 got=%b exp=100", {align_err_o, stall_o, dmem_req_o}); failures++;
    end
    @(negedge clk); mem_valid_i = 0; is_store_i = 0; is_load_i = 1; funct3_i = 3'b101; addr_i = 32'h102; #1;
    checks++;
    if ({unsigned_load_o, access_size_o, align_err_o, stall_o} !== 5'b10100) begin
      $display("FAIL lhu_decode got=%b exp=10100", {unsigned_load_o, access_size_o, align_err_o, stall_o}); failures++;
    end
    @(negedge clk); clr_inputs(); #1;
  endtask

  task automatic test_flush_resp();
    int done_cnt = 0;
    @(negedge clk);
    mem_valid_i = 1; is_load_i = 1; addr_i = 32'h300; funct3_i = 3'b010; #1;
    @(negedge clk); dmem_gnt_i = 1; #1;
    @(negedge clk); dmem_gnt_i = 0; flush_i = 1; #1;
    done_cnt += int'(done_o);
    @(negedge clk); clr_inputs(); #1;
    done_cnt += int'(done_o);
    checks++;
    if ({stall_o, dmem_req_o} !== 2'b10) begin
      $display("FAIL flush_drain got=%b exp=10", {stall_o, dmem_req_o}); failures++;
    end
    @(negedge clk); dmem_rvalid_i = 1; dmem_rdata_i = 32'h12345678; #1;
    done_cnt += int'(done_o);
    checks++;
    if (stall_o !== 1'b1) begin
      $display("FAIL flush_drain_rvalid_stall got=%b exp=1", stall_o); failures++;
    end
    @(negedge clk); clr_inputs(); #1;
    done_cnt += int'(done_o);
    checks++;
    if (stall_o !== 1'b0 || rdata_o !== 32'hDEADBEEF) begin
      $display("FAIL flush_idle got=%b rdata=%h exp=0 rdata=deadbeef", stall_o, rdata_o); failures++;
    end
    @(negedge clk); #1;
    done_cnt += int'(done_o);
    checks++;
    if (done_cnt !== 0) begin
      $display("FAIL flush_no_done got=%0d exp=0", done_cnt); failures++;
    end
  endtask

  task automatic test_flush_req();
    @(negedge clk);
    mem_valid_i = 1; is_load_i = 1; addr_i = 32'h380; funct3_i = 3'b010; #1;
    @(negedge clk); flush_i = 1; #1;
    checks++;
    if (dmem_req_o !== 1'b1) begin
      $display("FAIL flush_req_pre got=%b exp=1", dmem_req_o); failures++;
    end
    @(negedge clk); clr_inputs(); #1;
    checks++;
    if ({dmem_req_o, stall_o} !== 2'b00) begin
      $display("FAIL flush_req_drop got=%b exp=00", {dmem_req_o, stall_o}); failures++;
    end
    @(negedge clk); dmem_gnt_i = 1; dmem_rvalid_i = 1; dmem_rdata_i = 32'h0BADF00D; #1;
    @(negedge clk); clr_inputs(); #1;
    checks++;
    if ({dmem_req_o, done_o} !== 2'b00 || rdata_o !== 32'hDEADBEEF) begin
      $display("FAIL stray_rvalid got=%b rdata=%h exp=00 rdata=deadbeef", {dmem_req_o, done_o}, rdata_o); failures++;
    end
    @(negedge clk);
    mem_valid_i = 1; is_load_i = 1; addr_i = 32'h0; funct3_i = 3'b010; flush_i = 1; #1;
    checks++;
    if (stall_o !== 1'b0) begin
      $display("FAIL flush_idle_stall got=%b exp=0", stall_o); failures++;
    end
    @(negedge clk); clr_inputs(); #1;
    checks++;
    if (dmem_req_o !== 1'b0) begin
      $display("FAIL flush_idle_req got=%b exp=0", dmem_req_o); failures++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mem_valid_i = 1; is_load_i = 1; addr_i = 32'h10; funct3_i = 3'b010; #1;
    @(negedge clk); dmem_gnt_i = 1; #1;
    @(negedge clk); dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h11111111; #1;
    @(negedge clk); dmem_rvalid_i = 0; addr_i = 32'h20; #1;
    checks++;
    if ({done_o, stall_o} !== 2'b10 || rdata_o !== 32'h11111111) begin
      $display("FAIL b2b_first got=%b rdata=%h exp=10 rdata=11111111", {done_o, stall_o}, rdata_o); failures++;
    end
    @(negedge clk); #1;
    checks++;
    if ({done_o, stall_o} !== 2'b01) begin
      $display("FAIL b2b_accept got=%b exp=01", {done_o, stall_o}); failures++;
    end
    @(negedge clk); dmem_gnt_i = 1; #1;
    checks++;
    if ({dmem_req_o, dmem_addr_o} !== {1'b1, 32'h20}) begin
      $display("FAIL b2b_req got=%b/%h exp=1/00000020", dmem_req_o, dmem_addr_o); failures++;
    end
    @(negedge clk); dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h22222222; #1;
    @(negedge clk); clr_inputs(); #1;
    checks++;
    if (done_o !== 1'b1 || rdata_o !== 32'h22222222) begin
      $display("FAIL b2b_second got=%b rdata=%h exp=1 rdata=22222222", done_o, rdata_o); failures++;
    end
    @(negedge clk); #1;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    mem_valid_i = 1; is_load_i = 1; addr_i = 32'h400; funct3_i = 3'b010; #1;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({dmem_req_o, done_o, bus_err_o} !== 3'b100) begin
        $display("FAIL to_wait cyc=%0d got=%b exp=100", i, {dmem_req_o, done_o, bus_err_o}); failures++;
      end
    end
    @(negedge clk); clr_inputs(); #1;
    checks++;
    if ({dmem_req_o, done_o, bus_err_o, stall_o} !== 4'b0110) begin
      $display("FAIL to_fire got=%b exp=0110", {dmem_req_o, done_o, bus_err_o, stall_o}); failures++;
    end
    @(negedge clk); #1;
    checks++;
    if ({done_o, bus_err_o} !== 2'b00) begin
      $display("FAIL to_pulse got=%b exp=00", {done_o, bus_err_o}); failures++;
    end
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({dmem_req_o, stall_o, done_o, bus_err_o} !== 4'b1100) begin
        $display("FAIL nogrant_wait cyc=%0d got=%b exp=1100", i, {dmem_req_o, stall_o, done_o, bus_err_o}); failures++;
      end
    end
    rstn = 1'b0; clr_inputs();
    @(negedge clk); rstn = 1'b1;
    @(negedge clk); #1;
`endif
  endtask

  task automatic test_reset_mid();
    logic [104:0] rv;
    int done_cnt = 0;
    @(negedge clk);
    mem_valid_i = 1; is_store_i = 1; addr_i = 32'h500; wdata_i = 32'hCAFEF00D; funct3_i = 3'b010; #1;
    @(negedge clk); #1;
    checks++;
    if ({dmem_req_o, dmem_we_o} !== 2'b11) begin
      $display("FAIL rst_mid_pre got=%b exp=11", {dmem_req_o, dmem_we_o}); failures++;
    end
    #1; rstn = 1'b0; clr_inputs(); #1;
    rv = {stall_o, done_o, bus_err_o, dmem_req_o, dmem_we_o, dmem_addr_o,
          dmem_be_o, dmem_wdata_o, rdata_o};
    checks++;
    if (rv !== '0) begin
      $display("FAIL rst_mid_outputs got=%h exp=0", rv); failures++;
    end
    @(negedge clk); @(negedge clk); rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      done_cnt += int'(done_o) + int'(dmem_req_o) + int'(stall_o);
    end
    checks++;
    if (done_cnt !== 0) begin
      $display("FAIL rst_mid_after got=%0d exp=0", done_cnt); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_half();
    test_align_err();
    test_flush_resp();
    test_flush_req();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, bus-wait cycles before timeout; only used when LSU_TIMEOUT_EN is defined.
REQ-002 SHALL have port: clk  input  1  clock; all flops on rising edge.
REQ-003 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: flush_i in 1 pipeline flush; mem_valid_i in 1 valid instruction in MEM; is_load_i in 1; is_store_i in 1; addr_i in 32 effective address; wdata_i in 32 store data; funct3_i in 3 RV32 load/store funct3.
REQ-005 SHALL have decode outputs toward the MEM/WB register: byte_lane_o out 2; access_size_o out 2 (0 byte, 1 half, 2 word); unsigned_load_o out 1; align_err_o out 1.
REQ-006 SHALL have pipeline outputs: stall_o out 1 hold pipeline; done_o out 1 access complete this cycle; rdata_o out 32 raw captured load word; bus_err_o out 1 timeout pulse.
REQ-007 SHALL have bus ports: dmem_req_o out 1; dmem_we_o out 1; dmem_addr_o out 32 (word aligned, [1:0]=0); dmem_be_o out 4; dmem_wdata_o out 32; dmem_gnt_i in 1; dmem_rvalid_i in 1; dmem_rdata_i in 32.

Function
REQ-008 SHALL decode combinationally: byte_lane_o=addr_i[1:0]; funct3 000/100 byte, 001/101 half, 010 word; unsigned_load_o=funct3_i[2].
REQ-009 SHALL assert align_err_o when (load|store) and: half with addr_i[0]=1, word with addr_i[1:0]!=0, or funct3 in {011,110,111} (loads) / funct3_i[2]=1 (stores).
REQ-010 SHALL implement FSM states IDLE, REQ, RESP, DRAIN, DONE.
REQ-011 SHALL in IDLE, on mem_valid_i & (is_load_i|is_store_i) & !align_err_o & !flush_i, register address/be/wdata/we and go to REQ; stall_o=1 that cycle.
REQ-012 SHALL in IDLE with align_err_o=1 start no bus access and keep stall_o=0.
REQ-013 SHALL in REQ hold dmem_req_o=1 with stable addr/we/be/wdata until dmem_gnt_i=1, then go to RESP.
REQ-014 SHALL in RESP wait for dmem_rvalid_i (returned for loads and stores); on it capture dmem_rdata_i into rdata_o (loads only) and go to DONE.
REQ-015 SHALL in DONE drive done_o=1, stall_o=0 for exactly one cycle, then go to IDLE.
REQ-016 SHALL drive stall_o=1 in REQ, RESP, DRAIN and in the IDLE accept cycle; 0 otherwise.
REQ-017 SHALL generate dmem_be_o: byte 0001<<lane, half 0011<<lane, word 1111; dmem_wdata_o: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-018 SHALL on flush_i in REQ drop dmem_req_o next cycle and go to IDLE (no grant taken).
REQ-019 SHALL on flush_i in RESP go to DRAIN, wait for dmem_rvalid_i, discard data (rdata_o unchanged), then go to IDLE without done_o.
REQ-020 SHALL on flush_i in DONE still complete DONE then go to IDLE; flush_i in IDLE blocks acceptance.
REQ-021 SHALL treat dmem_rvalid_i outside RESP/DRAIN as ignored; protocol guarantees rvalid at least one cycle after gnt.
REQ-022 SHALL hold rdata_o until the next completed load.

Reset
REQ-023 SHALL on rstn=0 asynchronously enter IDLE; dmem_req_o, dmem_we_o, done_o, bus_err_o, stall_o=0; dmem_addr_o, dmem_be_o, dmem_wdata_o, rdata_o=0; timeout counter=0.
REQ-024 SHALL on reset mid-transaction abandon it; no done_o after reset release.

Configuration
REQ-025 SHALL, with LSU_TIMEOUT_EN defined, count cycles in REQ/RESP/DRAIN (cleared on entering REQ); when count reaches TIMEOUT_CYCLES, drop dmem_req_o, go to DONE with done_o=1 and bus_err_o=1 for that cycle (DRAIN: IDLE, bus_err_o=1, no done_o).
REQ-026 SHALL, without LSU_TIMEOUT_EN, omit the counter, tie bus_err_o=0 and wait indefinitely.

Verification
REQ-027 LW addr 0x100, gnt cycle 2, rvalid cycle 4 data 0xDEADBEEF -> be=1111, addr 0x100, rdata_o=0xDEADBEEF, done_o one cycle, stall_o high 4 cycles.
REQ-028 SB addr 0x203 wdata 0x000000A5 -> dmem_addr 0x200, be=1000, wdata 0xA5A5A5A5, we=1, byte_lane_o=3.
REQ-029 LH addr 0x101 -> align_err_o=1, dmem_req_o never asserted, stall_o=0.
REQ-030 LW, flush_i in RESP, rvalid data 0x12345678 -> rdata_o keeps prior value, no done_o, IDLE after rvalid.
REQ-031 LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, gnt never -> bus_err_o=1 and done_o=1 on same cycle after 8 REQ cycles, req dropped.
REQ-032 rstn low during REQ -> all outputs 0 immediately, IDLE after release.
